// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: in-order writeback FIFO for the regfile write port
// with youngest-match forwarding over all pending entries.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     rf_stall,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_rd,
  output logic [XLEN-1:0]          rf_wdata,
  input  logic [AW-1:0]            fwd_rs1,
  output logic                     fwd_hit1,
  output logic [XLEN-1:0]          fwd_data1,
  input  logic [AW-1:0]            fwd_rs2,
  output logic                     fwd_hit2,
  output logic [XLEN-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]   ent_rd   [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   slot     [DEPTH];
  logic            live     [DEPTH];
  logic            push;
  logic            pop;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid & in_ready & (in_rd != '0);
  assign rf_we    = (count != '0) & ~rf_stall;
  assign pop      = rf_we;
  assign rf_rd    = ent_rd[rd_ptr];
  assign rf_wdata = ent_data[rd_ptr];

  // pointers and occupancy; x0 accepts complete without enqueueing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // entry storage is never cleared, only overwritten
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[wr_ptr]   <= in_rd;
      ent_data[wr_ptr] <= in_data;
    end
  end

  // map age order (0 = head) to physical slots and occupancy
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot[k] = rd_ptr + PW'(k);
      live[k] = (CW'(k) < count);
    end
  end

  // lookup 1: scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (live[k] && fwd_rs1 != '0 &&
          ent_rd[slot[k]] == fwd_rs1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = ent_data[slot[k]];
      end
    end
  end

  // lookup 2: same scan for the second read port
  always_comb begin
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (live[k] && fwd_rs2 != '0 &&
          ent_rd[slot[k]] == fwd_rs2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = ent_data[slot[k]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: directed cases plus random traffic
// checked against a queue-based reference model.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        rf_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [4:0]  fwd_rs1;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic [4:0]  fwd_rs2;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  regfile_writeback_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .rf_stall  (rf_stall),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .fwd_rs1   (fwd_rs1),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_rs2   (fwd_rs2),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].rd == rs) return {1'b1, q[i].data};
    return '0;
  endfunction

  // one cycle: drive at negedge, check, then advance model at posedge
  task automatic step(input logic v, input logic [4:0] rd,
                      input logic [31:0] d, input logic st,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic rn);
    logic        e_rdy;
    logic        e_we;
    logic [32:0] f1;
    logic [32:0] f2;
    @(negedge clk);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    rf_stall = st;
    fwd_rs1  = r1;
    fwd_rs2  = r2;
    rst_n    = rn;
    #1;
    e_rdy = (q.size() != 4);
    e_we  = (q.size() != 0) && !st;
    f1    = model_fwd(r1);
    f2    = model_fwd(r2);
    check("in_ready", 32'(in_ready), 32'(e_rdy));
    check("count", 32'(count), 32'(q.size()));
    check("rf_we", 32'(rf_we), 32'(e_we));
    if (e_we) begin
      check("rf_rd", 32'(rf_rd), 32'(q[0].rd));
      check("rf_wdata", rf_wdata, q[0].data);
    end
    check("fwd_hit1", 32'(fwd_hit1), 32'(f1[32]));
    check("fwd_data1", fwd_data1, f1[31:0]);
    check("fwd_hit2", 32'(fwd_hit2), 32'(f2[32]));
    check("fwd_data2", fwd_data2, f2[31:0]);
    @(posedge clk);
    if (!rn) begin
      q.delete();
    end else begin
      if (e_we) void'(q.pop_front());
      if (v && e_rdy && rd != 5'd0)
        q.push_back('{rd: rd, data: d});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    rf_stall = 1'b0;
    fwd_rs1  = '0;
    fwd_rs2  = '0;
    repeat (2) @(posedge clk);

    // single write, then drain
    step(1, 5, 32'hDEADBEEF, 0, 5, 0, 1);
    step(0, 0, 0, 0, 5, 0, 1);
    step(0, 0, 0, 0, 5, 0, 1);
    // x0 write is dropped
    step(1, 0, 32'h1234, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // fill under stall, 5th offer refused, then drain
    for (int i = 1; i <= 4; i++)
      step(1, 5'(i), 32'(i * 16), 1, 5'(i), 1, 1);
    step(1, 9, 32'h99, 1, 9, 4, 1);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 0, 1, 4, 1);
    // youngest-match forwarding
    step(1, 3, 1, 1, 3, 4, 1);
    step(1, 3, 2, 1, 3, 4, 1);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 3, 4, 1);
    // full queue, stall released, continuous offers
    for (int i = 0; i < 4; i++)
      step(1, 5'(i + 6), 32'(i), 1, 6, 9, 1);
    for (int i = 0; i < 6; i++)
      step(1, 5'(i + 10), 32'(i + 100), 0, 10, 12, 1);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 0, 14, 15, 1);
    // reset with pending entries discards them
    for (int i = 0; i < 3; i++)
      step(1, 5'(i + 20), 32'(i + 7), 1, 20, 22, 1);
    step(0, 0, 0, 0, 20, 22, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 20, 22, 1);

    // random traffic with varying stall pressure
    for (int i = 0; i < 3000; i++) begin
      int sp;
      sp = (i / 500) % 3;
      step(1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)),
           $urandom(),
           1'($urandom_range(0, 3) < sp + 1 ? 1 : 0),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)),
           1'($urandom_range(0, 199) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
